// File: rtl/nord_useq_pkg.sv
// Shared encodings for the microprogram sequencer: next-address control codes
// and the one-hot micro-cycle phase ring.
package nord_useq_pkg;

  typedef enum logic [2:0] {
    NXT_CONT = 3'd0,
    NXT_JUMP = 3'd1,
    NXT_CJMP = 3'd2,
    NXT_CALL = 3'd3,
    NXT_RET  = 3'd4,
    NXT_MAP  = 3'd5,
    NXT_LOOP = 3'd6,
    NXT_CRET = 3'd7
  } nxt_e;

  typedef enum logic [4:0] {
    PH_P1 = 5'b00001,
    PH_P2 = 5'b00010,
    PH_P3 = 5'b00100,
    PH_P4 = 5'b01000,
    PH_P5 = 5'b10000
  } phase_e;

endpackage

// File: rtl/useq_stack.sv
// Micro-subroutine return stack. Circular buffer: a push onto a full stack
// overwrites the oldest entry, so the newest DEPTH return addresses survive.
module useq_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] din_i,
  output logic [AW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CNW = $clog2(DEPTH + 1);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wp_q, wp_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]  rd_ptr;

  assign rd_ptr  = wp_q - PW'(1);
  assign top_o   = mem_q[rd_ptr];
  assign full_o  = (cnt_q == CNW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      wp_d = wp_q + PW'(1);
      if (!full_o) cnt_d = cnt_q + CNW'(1);
    end else if (pop_i && !empty_o) begin
      wp_d  = rd_ptr;
      cnt_d = cnt_q - CNW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: 5-phase micro-cycle ring, control-store address
// register, next-address selection from the current MIR, and loop counter.
module micro_sequencer
  import nord_useq_pkg::*;
#(
  parameter int AW     = 12,
  parameter int SDEPTH = 4,
  parameter int CW     = 5
) (
  input  logic          clk,
  input  logic          MCL,
  input  logic          HOLD,
  input  logic [2:0]    MIR_NXT,
  input  logic [AW-1:0] MIR_NADR,
  input  logic [2:0]    MIR_CSEL,
  input  logic [7:0]    COND,
  input  logic [AW-1:0] IRMAP,
  input  logic          WSHC,
  input  logic [CW-1:0] LCNT,
  output logic [AW-1:0] ROMA,
  output logic          MIRKL,
  output logic          T1,
  output logic          T3,
  output logic          T5,
  output logic          ACTLOOP,
  output logic          STKERR
);

  phase_e        phase_q, phase_d;
  logic          run_q, run_d;
  logic [AW-1:0] roma_q, roma_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stkerr_q, stkerr_d;

  nxt_e          nxt;
  logic          step;
  logic          cond_bit;
  logic [AW-1:0] inc_adr;
  logic [AW-1:0] next_adr;
  logic          push_req, pop_req, err_req, dec_req;
  logic [AW-1:0] stk_top;
  logic          stk_full, stk_empty;

  assign nxt      = nxt_e'(MIR_NXT);
  assign cond_bit = COND[MIR_CSEL];
  assign inc_adr  = roma_q + AW'(1);
  // MIR is garbage until the first MIRKL after reset, so the first P4 is skipped.
  assign step     = (phase_q == PH_P4) && run_q;

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_P1:   phase_d = PH_P2;
      PH_P2:   phase_d = PH_P3;
      PH_P3:   phase_d = PH_P4;
      PH_P4:   phase_d = PH_P5;
      PH_P5:   phase_d = HOLD ? PH_P5 : PH_P1;
      default: phase_d = PH_P1;
    endcase
  end

  always_comb begin
    next_adr = inc_adr;
    push_req = 1'b0;
    pop_req  = 1'b0;
    err_req  = 1'b0;
    dec_req  = 1'b0;
    case (nxt)
      NXT_CONT: next_adr = inc_adr;
      NXT_JUMP: next_adr = MIR_NADR;
      NXT_CJMP: next_adr = cond_bit ? MIR_NADR : inc_adr;
      NXT_CALL: begin
        next_adr = MIR_NADR;
        push_req = 1'b1;
        err_req  = stk_full;
      end
      NXT_RET: begin
        pop_req  = 1'b1;
        err_req  = stk_empty;
        next_adr = stk_empty ? '0 : stk_top;
      end
      NXT_MAP:  next_adr = IRMAP;
      NXT_LOOP: begin
        dec_req  = (cnt_q != '0);
        next_adr = dec_req ? roma_q : inc_adr;
      end
      NXT_CRET: begin
        if (cond_bit) begin
          pop_req  = 1'b1;
          err_req  = stk_empty;
          next_adr = stk_empty ? '0 : stk_top;
        end
      end
      default: next_adr = inc_adr;
    endcase
  end

  always_comb begin
    run_d    = run_q | ((phase_q == PH_P5) && !HOLD);
    roma_d   = step ? next_adr : roma_q;
    stkerr_d = stkerr_q | (step & err_req);
    cnt_d    = cnt_q;
    // A same-cycle counter load wins over the loop decrement.
    if (WSHC)                 cnt_d = LCNT;
    else if (step && dec_req) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge MCL) begin
    if (MCL) begin
      phase_q  <= PH_P1;
      run_q    <= 1'b0;
      roma_q   <= '0;
      cnt_q    <= '0;
      stkerr_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      run_q    <= run_d;
      roma_q   <= roma_d;
      cnt_q    <= cnt_d;
      stkerr_q <= stkerr_d;
    end
  end

  useq_stack #(
    .AW    (AW),
    .DEPTH (SDEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (MCL),
    .push_i  (step & push_req),
    .pop_i   (step & pop_req),
    .din_i   (inc_adr),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign ROMA    = roma_q;
  assign T1      = (phase_q == PH_P1) & ~MCL;
  assign T3      = (phase_q == PH_P3) & ~MCL;
  assign T5      = (phase_q == PH_P5) & ~MCL;
  assign MIRKL   = (phase_q == PH_P5) & ~HOLD & ~MCL;
  assign ACTLOOP = (nxt == NXT_LOOP) & (cnt_q != '0);
  assign STKERR  = stkerr_q;

endmodule
